multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, max consecutive wait cycles per memory access; 0 disables the watchdog.
REQ-002 Parameter OPCODE_W, default 7, opcode field width.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 opcode  input  OPCODE_W  instruction opcode from the instruction register.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 mem_ready  input  1  memory handshake; the access completes in any cycle it is high.
REQ-008 PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc  output  1 each  datapath enables/select.
REQ-009 ResultSrc, ALUSrcA, ALUSrcB, ALUOp  output  2 each  datapath selects.
REQ-010 ImmSrc  output  3  immediate format.
REQ-011 illegal, mem_timeout  output  1 each  single-cycle event pulses.

Function
REQ-012 FSM states SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, and JAL (the last only under REQ-030).
REQ-013 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; IRWrite and PCWrite high only when mem_ready=1, then -> DECODE; otherwise stay.
REQ-014 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00; lw(0000011) or sw(0100011) -> MEMADR, R(0110011) -> EXECUTER, I(0010011) -> EXECUTEI, beq(1100011) -> BEQ, jal(1101111) -> JAL; any other opcode -> FETCH with illegal=1 for that cycle.
REQ-015 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; lw -> MEMREAD, sw -> MEMWRITE.
REQ-016 MEMREAD: ResultSrc=00, AdrSrc=1; -> MEMWB when mem_ready=1, otherwise stay.
REQ-017 MEMWB: ResultSrc=01, RegWrite=1; -> FETCH.
REQ-018 MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1 held until mem_ready=1, then -> FETCH.
REQ-019 EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10; EXECUTEI: same except ALUSrcB=01; both -> ALUWB.
REQ-020 ALUWB: ResultSrc=00, RegWrite=1; -> FETCH.
REQ-021 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00; PCWrite=zero; -> FETCH.
REQ-022 Outputs not listed for a state SHALL be 0; no output SHALL ever be X.
REQ-023 ImmSrc SHALL be combinational from opcode in every state: I/lw 000, sw 001, beq 010, jal 011, others 000.
REQ-024 A wait counter SHALL clear on entry to FETCH, MEMREAD or MEMWRITE and increment each cycle in that state while mem_ready=0.
REQ-025 When the counter equals TIMEOUT_CYCLES (nonzero) and mem_ready=0: mem_timeout=1 for one cycle, IRWrite/PCWrite/MemWrite forced 0, next state FETCH with the counter cleared.
REQ-026 If mem_ready=1 in the timeout cycle, the completion SHALL take priority and no timeout SHALL occur.
REQ-027 Counter width SHALL be $clog2(TIMEOUT_CYCLES+1), minimum 1.

Reset
REQ-028 While rst_n=0: state=FETCH, counter=0, and all registered state cleared; outputs then reflect FETCH decoding (PCWrite/IRWrite gated by mem_ready).
REQ-029 Reset asserted mid-access SHALL abort the access immediately with no RegWrite or MemWrite after assertion.

Configuration
REQ-030 Macro MULTICYCLE_JAL_EN defined: the JAL state exists (ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1; -> ALUWB). Undefined: opcode 1101111 is illegal per REQ-014 and ImmSrc=000 for it.

Structure
REQ-031 A shared package SHALL hold the state enum, opcode constants, and ResultSrc/ALUSrcA/ALUSrcB/ALUOp/ImmSrc encodings.
REQ-032 The wait counter and timeout compare SHALL be sub-module mem_wait_timer; the FSM stays in multicycle_controller.

Verification
REQ-033 Reset, then R-type with mem_ready=1 -> FETCH, DECODE, EXECUTER, ALUWB (RegWrite=1), FETCH; 4 cycles.
REQ-034 lw with mem_ready low for 3 cycles in MEMREAD -> stays in MEMREAD 4 cycles, then MEMWB with RegWrite=1.
REQ-035 beq with zero=1 -> PCWrite=1 in BEQ; zero=0 -> PCWrite=0.
REQ-036 Opcode 1111111 -> illegal=1 in DECODE, next state FETCH, no writes.
REQ-037 TIMEOUT_CYCLES=4, mem_ready held 0 in MEMWRITE -> mem_timeout pulses once in the 5th cycle, then FETCH; rerun with mem_ready=1 in that cycle -> no timeout.
REQ-038 jal with and without MULTICYCLE_JAL_EN -> JAL then ALUWB versus illegal pulse.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// +--------------------------------------------------------------------+
// | multicycle_controller_pkg                                          |
// | States, opcodes and datapath select encodings for the controller.  |
// | Optional macro: MULTICYCLE_JAL_EN (adds the JAL state).            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9
`ifdef MULTICYCLE_JAL_EN
    ,
    S_JAL      = 4'd10
`endif
  } state_t;

  localparam logic [6:0] c_op_lw  = 7'b0000011;
  localparam logic [6:0] c_op_sw  = 7'b0100011;
  localparam logic [6:0] c_op_r   = 7'b0110011;
  localparam logic [6:0] c_op_i   = 7'b0010011;
  localparam logic [6:0] c_op_beq = 7'b1100011;
  localparam logic [6:0] c_op_jal = 7'b1101111;

  localparam logic [1:0] c_res_alu  = 2'b00;
  localparam logic [1:0] c_res_data = 2'b01;
  localparam logic [1:0] c_res_next = 2'b10;

  localparam logic [1:0] c_srca_pc    = 2'b00;
  localparam logic [1:0] c_srca_oldpc = 2'b01;
  localparam logic [1:0] c_srca_rs1   = 2'b10;

  localparam logic [1:0] c_srcb_rs2  = 2'b00;
  localparam logic [1:0] c_srcb_imm  = 2'b01;
  localparam logic [1:0] c_srcb_four = 2'b10;

  localparam logic [1:0] c_aluop_add   = 2'b00;
  localparam logic [1:0] c_aluop_sub   = 2'b01;
  localparam logic [1:0] c_aluop_funct = 2'b10;

  localparam logic [2:0] c_imm_i = 3'b000;
  localparam logic [2:0] c_imm_s = 3'b001;
  localparam logic [2:0] c_imm_b = 3'b010;
  localparam logic [2:0] c_imm_j = 3'b011;

endpackage

`default_nettype wire

// File: rtl/multicycle_controller_mem_wait_timer.sv
// +--------------------------------------------------------------------+
// | mem_wait_timer                                                     |
// | Counts stalled cycles of a memory access and flags the timeout.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module mem_wait_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic mem_ready,
  output logic timeout
);

  localparam int  c_cw      = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit  c_enabled = (TIMEOUT_CYCLES != 0);

  logic [c_cw-1:0] count_q, count_d;
  logic            stalled;

  assign stalled = c_enabled && active && !mem_ready;
  assign timeout = stalled && (count_q == c_cw'(TIMEOUT_CYCLES));

  // Any cycle that does not continue a stall restarts the count, which also
  // covers clearing on entry to a wait state and after a timeout.
  always_comb begin
    count_d = '0;
    if (stalled && !timeout) begin
      count_d = count_q + c_cw'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
// +--------------------------------------------------------------------+
// | multicycle_controller                                              |
// | Multicycle RISC-V control FSM with memory wait watchdog.           |
// | Optional macro: MULTICYCLE_JAL_EN (adds the JAL state).            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int OPCODE_W       = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                PCWrite,
  output logic                IRWrite,
  output logic                RegWrite,
  output logic                MemWrite,
  output logic                AdrSrc,
  output logic [1:0]          ResultSrc,
  output logic [1:0]          ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ALUOp,
  output logic [2:0]          ImmSrc,
  output logic                illegal,
  output logic                mem_timeout
);

  state_t state_q, state_d;
  logic   wait_state;
  logic   is_lw, is_sw, is_r, is_i, is_beq, is_jal;

  assign is_lw  = (opcode == OPCODE_W'(c_op_lw));
  assign is_sw  = (opcode == OPCODE_W'(c_op_sw));
  assign is_r   = (opcode == OPCODE_W'(c_op_r));
  assign is_i   = (opcode == OPCODE_W'(c_op_i));
  assign is_beq = (opcode == OPCODE_W'(c_op_beq));
`ifdef MULTICYCLE_JAL_EN
  assign is_jal = (opcode == OPCODE_W'(c_op_jal));
`else
  assign is_jal = 1'b0;
`endif

  always_comb begin
    ImmSrc = c_imm_i;
    if (is_sw)       ImmSrc = c_imm_s;
    else if (is_beq) ImmSrc = c_imm_b;
    else if (is_jal) ImmSrc = c_imm_j;
  end

  assign wait_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                      (state_q == S_MEMWRITE);

  mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_mem_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .active    (wait_state),
    .mem_ready (mem_ready),
    .timeout   (mem_timeout)
  );

  always_comb begin
    state_d   = state_q;
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = c_res_alu;
    ALUSrcA   = c_srca_pc;
    ALUSrcB   = c_srcb_rs2;
    ALUOp     = c_aluop_add;
    illegal   = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        ALUSrcB   = c_srcb_four;
        ResultSrc = c_res_next;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA = c_srca_oldpc;
        ALUSrcB = c_srcb_imm;
        if (is_lw || is_sw) state_d = S_MEMADR;
        else if (is_r)      state_d = S_EXECUTER;
        else if (is_i)      state_d = S_EXECUTEI;
        else if (is_beq)    state_d = S_BEQ;
`ifdef MULTICYCLE_JAL_EN
        else if (is_jal)    state_d = S_JAL;
`endif
        else begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEMADR: begin
        ALUSrcA = c_srca_rs1;
        ALUSrcB = c_srcb_imm;
        if (is_lw)      state_d = S_MEMREAD;
        else if (is_sw) state_d = S_MEMWRITE;
        else            state_d = S_FETCH;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = c_res_data;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECUTER, S_EXECUTEI: begin
        ALUSrcA = c_srca_rs1;
        ALUSrcB = (state_q == S_EXECUTEI) ? c_srcb_imm : c_srcb_rs2;
        ALUOp   = c_aluop_funct;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA = c_srca_rs1;
        ALUOp   = c_aluop_sub;
        PCWrite = zero;
        state_d = S_FETCH;
      end
`ifdef MULTICYCLE_JAL_EN
      S_JAL: begin
        ALUSrcA = c_srca_oldpc;
        ALUSrcB = c_srcb_four;
        PCWrite = 1'b1;
        state_d = S_ALUWB;
      end
`endif
      default: state_d = S_FETCH;
    endcase
    // A watchdog expiry abandons the access without committing anything.
    if (mem_timeout) begin
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      MemWrite = 1'b0;
      state_d  = S_FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// +--------------------------------------------------------------------+
// | tb_multicycle_controller                                           |
// | Directed self-checking bench for multicycle_controller.            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0] ImmSrc;
  logic       illegal, mem_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  // {PCWrite,IRWrite,RegWrite,MemWrite,AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ALUOp}
  localparam logic [12:0] c_fetch_rdy  = 13'b1_1_0_0_0_10_00_10_00;
  localparam logic [12:0] c_fetch_idle = 13'b0_0_0_0_0_10_00_10_00;
  localparam logic [12:0] c_decode     = 13'b0_0_0_0_0_00_01_01_00;
  localparam logic [12:0] c_memadr     = 13'b0_0_0_0_0_00_10_01_00;
  localparam logic [12:0] c_memread    = 13'b0_0_0_0_1_00_00_00_00;
  localparam logic [12:0] c_memwb      = 13'b0_0_1_0_0_01_00_00_00;
  localparam logic [12:0] c_memwrite   = 13'b0_0_0_1_1_00_00_00_00;
  localparam logic [12:0] c_memwr_to   = 13'b0_0_0_0_1_00_00_00_00;
  localparam logic [12:0] c_exec_r     = 13'b0_0_0_0_0_00_10_00_10;
  localparam logic [12:0] c_exec_i     = 13'b0_0_0_0_0_00_10_01_10;
  localparam logic [12:0] c_aluwb      = 13'b0_0_1_0_0_00_00_00_00;
  localparam logic [12:0] c_beq_t      = 13'b1_0_0_0_0_00_10_00_01;
  localparam logic [12:0] c_beq_f      = 13'b0_0_0_0_0_00_10_00_01;
  localparam logic [12:0] c_jal        = 13'b1_0_0_0_0_00_01_10_00;

  multicycle_controller #(
    .TIMEOUT_CYCLES(4),
    .OPCODE_W(7)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .ImmSrc(ImmSrc), .illegal(illegal), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] sig();
    return {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b0; opcode = 7'h00; zero = 1'b0;
    tick(); tick();
    n_checks++; if (sig() !== c_fetch_idle) begin n_fail++; $display("FAIL reset_idle: got %b want %b", sig(), c_fetch_idle); end
    n_checks++; if ({illegal, mem_timeout} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got %b want 00", {illegal, mem_timeout}); end
    mem_ready = 1'b1; #1;
    n_checks++; if (sig() !== c_fetch_rdy) begin n_fail++; $display("FAIL reset_ready: got %b want %b", sig(), c_fetch_rdy); end
    rst_n = 1'b1;
  endtask

  task automatic test_rtype();
    opcode = 7'b0110011; mem_ready = 1'b1; #1;
    n_checks++; if (sig() !== c_fetch_rdy) begin n_fail++; $display("FAIL r_fetch: got %b want %b", sig(), c_fetch_rdy); end
    tick();
    n_checks++; if (sig() !== c_decode) begin n_fail++; $display("FAIL r_decode: got %b want %b", sig(), c_decode); end
    n_checks++; if (ImmSrc !== 3'b000) begin n_fail++; $display("FAIL r_immsrc: got %b want 000", ImmSrc); end
    tick();
    n_checks++; if (sig() !== c_exec_r) begin n_fail++; $display("FAIL r_exec: got %b want %b", sig(), c_exec_r); end
    tick();
    n_checks++; if (sig() !== c_aluwb) begin n_fail++; $display("FAIL r_aluwb: got %b want %b", sig(), c_aluwb); end
    tick();
    n_checks++; if (sig() !== c_fetch_rdy) begin n_fail++; $display("FAIL r_refetch: got %b want %b", sig(), c_fetch_rdy); end
  endtask

  task automatic test_itype();
    opcode = 7'b0010011; mem_ready = 1'b1; #1;
    tick();
    n_checks++; if (sig() !== c_decode) begin n_fail++; $display("FAIL i_decode: got %b want %b", sig(), c_decode); end
    tick();
    n_checks++; if (sig() !== c_exec_i) begin n_fail++; $display("FAIL i_exec: got %b want %b", sig(), c_exec_i); end
    tick();
    n_checks++; if (sig() !== c_aluwb) begin n_fail++; $display("FAIL i_aluwb: got %b want %b", sig(), c_aluwb); end
    tick();
    n_checks++; if (sig() !== c_fetch_rdy) begin n_fail++; $display("FAIL i_refetch: got %b want %b", sig(), c_fetch_rdy); end
  endtask

  task automatic test_lw_wait();
    opcode = 7'b0000011; mem_ready = 1'b1; #1;
    tick(); tick();
    n_checks++; if (sig() !== c_memadr) begin n_fail++; $display("FAIL lw_memadr: got %b want %b", sig(), c_memadr); end
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (sig() !== c_memread) begin n_fail++; $display("FAIL lw_memread_wait%0d: got %b want %b", i, sig(), c_memread); end
      tick();
    end
    mem_ready = 1'b1; #1;
    n_checks++; if (sig() !== c_memread) begin n_fail++; $display("FAIL lw_memread_done: got %b want %b", sig(), c_memread); end
    tick();
    n_checks++; if (sig() !== c_memwb) begin n_fail++; $display("FAIL lw_memwb: got %b want %b", sig(), c_memwb); end
    tick();
    n_checks++; if (sig() !== c_fetch_rdy) begin n_fail++; $display("FAIL lw_refetch: got %b want %b", sig(), c_fetch_rdy); end
  endtask

  task automatic test_beq();
    for (int z = 1; z >= 0; z--) begin
      opcode = 7'b1100011; zero = z[0]; mem_ready = 1'b1; #1;
      tick();
      n_checks++; if (ImmSrc !== 3'b010) begin n_fail++; $display("FAIL beq_immsrc: got %b want 010", ImmSrc); end
      tick();
      n_checks++; if (sig() !== (z[0] ? c_beq_t : c_beq_f)) begin n_fail++; $display("FAIL beq_zero%0d: got %b want %b", z, sig(), (z[0] ? c_beq_t : c_beq_f)); end
      tick();
      n_checks++; if (sig() !== c_fetch_rdy) begin n_fail++; $display("FAIL beq_refetch: got %b want %b", sig(), c_fetch_rdy); end
    end
    zero = 1'b0;
  endtask

  task automatic test_illegal();
    opcode = 7'b1111111; mem_ready = 1'b1; #1;
    tick();
    n_checks++; if (sig() !== c_decode || illegal !== 1'b1) begin n_fail++; $display("FAIL illegal_decode: got %b/%b want %b/1", sig(), illegal, c_decode); end
    mem_ready = 1'b0;
    tick();
    n_checks++; if (sig() !== c_fetch_idle || illegal !== 1'b0) begin n_fail++; $display("FAIL illegal_fetch: got %b/%b want %b/0", sig(), illegal, c_fetch_idle); end
    mem_ready = 1'b1; #1;
  endtask

  task automatic test_timeout();
    opcode = 7'b0100011; mem_ready = 1'b1; #1;
    tick();
    n_checks++; if (ImmSrc !== 3'b001) begin n_fail++; $display("FAIL sw_immsrc: got %b want 001", ImmSrc); end
    tick(); mem_ready = 1'b0; tick();
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (sig() !== c_memwrite || mem_timeout !== 1'b0) begin n_fail++; $display("FAIL to_wait%0d: got %b/%b want %b/0", i, sig(), mem_timeout, c_memwrite); end
      tick();
    end
    n_checks++; if (sig() !== c_memwr_to || mem_timeout !== 1'b1) begin n_fail++; $display("FAIL to_fire: got %b/%b want %b/1", sig(), mem_timeout, c_memwr_to); end
    tick();
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (sig() !== c_fetch_idle || mem_timeout !== 1'b0) begin n_fail++; $display("FAIL to_fetch_wait%0d: got %b/%b want %b/0", i, sig(), mem_timeout, c_fetch_idle); end
      tick();
    end
    n_checks++; if (mem_timeout !== 1'b1) begin n_fail++; $display("FAIL to_fetch_fire: got %b want 1", mem_timeout); end
    tick();
    mem_ready = 1'b1; #1;
    n_checks++; if (sig() !== c_fetch_rdy || mem_timeout !== 1'b0) begin n_fail++; $display("FAIL to_recover: got %b/%b want %b/0", sig(), mem_timeout, c_fetch_rdy); end
    tick(); tick(); mem_ready = 1'b0; tick();
    repeat (4) tick();
    mem_ready = 1'b1; #1;
    n_checks++; if (sig() !== c_memwrite || mem_timeout !== 1'b0) begin n_fail++; $display("FAIL to_ready_wins: got %b/%b want %b/0", sig(), mem_timeout, c_memwrite); end
    tick();
    n_checks++; if (sig() !== c_fetch_rdy) begin n_fail++; $display("FAIL to_ready_refetch: got %b want %b", sig(), c_fetch_rdy); end
  endtask

  task automatic test_reset_abort();
    opcode = 7'b0100011; mem_ready = 1'b1; #1;
    tick(); tick(); mem_ready = 1'b0; tick();
    n_checks++; if (sig() !== c_memwrite) begin n_fail++; $display("FAIL abort_pre: got %b want %b", sig(), c_memwrite); end
    #3 rst_n = 1'b0; #1;
    n_checks++; if (sig() !== c_fetch_idle) begin n_fail++; $display("FAIL abort_reset: got %b want %b", sig(), c_fetch_idle); end
    tick(); rst_n = 1'b1; mem_ready = 1'b1; #1;
  endtask

  task automatic test_jal();
    opcode = 7'b1101111; mem_ready = 1'b1; #1;
    tick();
`ifdef MULTICYCLE_JAL_EN
    n_checks++; if (illegal !== 1'b0 || ImmSrc !== 3'b011) begin n_fail++; $display("FAIL jal_decode: got %b/%b want 0/011", illegal, ImmSrc); end
    tick();
    n_checks++; if (sig() !== c_jal) begin n_fail++; $display("FAIL jal_state: got %b want %b", sig(), c_jal); end
    tick();
    n_checks++; if (sig() !== c_aluwb) begin n_fail++; $display("FAIL jal_aluwb: got %b want %b", sig(), c_aluwb); end
`else
    n_checks++; if (illegal !== 1'b1 || ImmSrc !== 3'b000) begin n_fail++; $display("FAIL jal_illegal: got %b/%b want 1/000", illegal, ImmSrc); end
`endif
    tick();
    n_checks++; if (sig() !== c_fetch_rdy) begin n_fail++; $display("FAIL jal_refetch: got %b want %b", sig(), c_fetch_rdy); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_lw_wait();
    test_beq();
    test_illegal();
    test_timeout();
    test_reset_abort();
    test_jal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
